// File: rtl/mmul_index_sequencer.sv
// Matrix-multiply (i, j, k) index sequencer with valid/ready handshake.
// Define MMUL_SEQ_ADDR_EN to build the incremental a/b/c operand address counters.
module mmul_index_sequencer #(
   parameter int RA = 2,
   parameter int CA = 2,
   parameter int RB = 2,
   parameter int CB = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        ready,
   output logic        valid,
   output logic [31:0] i,
   output logic [31:0] j,
   output logic [31:0] k,
   output logic        first_k,
   output logic        last_k,
   output logic [31:0] a_addr,
   output logic [31:0] b_addr,
   output logic [31:0] c_addr,
   output logic        busy,
   output logic        done,
   output logic        cfg_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic        CFG_BAD = (CA != RB) || (RA == 0) || (CA == 0) || (RB == 0) || (CB == 0);
   localparam logic [31:0] RA_M1   = 32'(RA - 1);
   localparam logic [31:0] RB_M1   = 32'(RB - 1);
   localparam logic [31:0] CB_M1   = 32'(CB - 1);

   logic [1:0] state;
   logic       launch, hs, k_end, j_end, fin, kstep, jstep, istep;

   assign cfg_err = CFG_BAD;
   assign valid   = (state == S_RUN);
   assign busy    = (state == S_RUN);
   assign done    = (state == S_DONE);
   assign first_k = valid && (k == 32'd0);
   assign last_k  = valid && (k == RB_M1);

   // Step qualifiers shared by the index and address counters; the final tuple never steps.
   assign launch = (state == S_IDLE) && start && !CFG_BAD;
   assign hs     = valid && ready;
   assign k_end  = (k == RB_M1);
   assign j_end  = (j == CB_M1);
   assign fin    = hs && k_end && j_end && (i == RA_M1);
   assign kstep  = hs && !fin && !k_end;
   assign jstep  = hs && !fin && k_end && !j_end;
   assign istep  = hs && !fin && k_end && j_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         i     <= '0;
         j     <= '0;
         k     <= '0;
      end else begin
         case (state)
            S_IDLE: if (launch) begin
               state <= S_RUN;
               i     <= '0;
               j     <= '0;
               k     <= '0;
            end
            S_RUN: begin
               if (fin) state <= S_DONE;
               if (kstep) k <= k + 32'd1;
               if (jstep) begin
                  k <= '0;
                  j <= j + 32'd1;
               end
               if (istep) begin
                  k <= '0;
                  j <= '0;
                  i <= i + 32'd1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef MMUL_SEQ_ADDR_EN
   logic [31:0] a_base;

   // a_base tracks i*CA so that a k wrap can return a_addr to the row start without multiplying.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_base <= '0;
         a_addr <= '0;
         b_addr <= '0;
         c_addr <= '0;
      end else if (launch) begin
         a_base <= '0;
         a_addr <= '0;
         b_addr <= '0;
         c_addr <= '0;
      end else if (kstep) begin
         a_addr <= a_addr + 32'd1;
         b_addr <= b_addr + 32'(CB);
      end else if (jstep) begin
         a_addr <= a_base;
         b_addr <= j + 32'd1;
         c_addr <= c_addr + 32'd1;
      end else if (istep) begin
         a_base <= a_base + 32'(CA);
         a_addr <= a_base + 32'(CA);
         b_addr <= '0;
         c_addr <= c_addr + 32'd1;
      end
   end
`else
   assign a_addr = '0;
   assign b_addr = '0;
   assign c_addr = '0;
`endif

endmodule

// File: tb/tb_mmul_index_sequencer.sv
// Directed self-checking bench for mmul_index_sequencer: default 2x2x2, a 2x3*3x2 shape,
// and a mismatched configuration that must report cfg_err.
module tb_mmul_index_sequencer;

   logic clk, rst;
   int   n_checks = 0;
   int   n_errors = 0;

   logic        start0, ready0, valid0, first_k0, last_k0, busy0, done0, cfg_err0;
   logic [31:0] i0, j0, k0, a0, b0, c0;
   logic        start1, ready1, valid1, first_k1, last_k1, busy1, done1, cfg_err1;
   logic [31:0] i1, j1, k1, a1, b1, c1;
   logic        start2, ready2, valid2, first_k2, last_k2, busy2, done2, cfg_err2;
   logic [31:0] i2, j2, k2, a2, b2, c2;

   mmul_index_sequencer #(.RA(2), .CA(2), .RB(2), .CB(2)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .ready(ready0), .valid(valid0),
      .i(i0), .j(j0), .k(k0), .first_k(first_k0), .last_k(last_k0),
      .a_addr(a0), .b_addr(b0), .c_addr(c0), .busy(busy0), .done(done0), .cfg_err(cfg_err0));

   mmul_index_sequencer #(.RA(2), .CA(3), .RB(3), .CB(2)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .ready(ready1), .valid(valid1),
      .i(i1), .j(j1), .k(k1), .first_k(first_k1), .last_k(last_k1),
      .a_addr(a1), .b_addr(b1), .c_addr(c1), .busy(busy1), .done(done1), .cfg_err(cfg_err1));

   mmul_index_sequencer #(.RA(2), .CA(3), .RB(2), .CB(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .ready(ready2), .valid(valid2),
      .i(i2), .j(j2), .k(k2), .first_k(first_k2), .last_k(last_k2),
      .a_addr(a2), .b_addr(b2), .c_addr(c2), .busy(busy2), .done(done2), .cfg_err(cfg_err2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // mode 0: ready=1; mode 1: ready pattern 1,0,0 repeating; mode 2: ready=1 plus start at beat 3
   task automatic run0(input int mode);
      int ei, ej, ek, beats, cyc;
      ei = 0; ej = 0; ek = 0; beats = 0; cyc = 0;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      check("latency_valid", 32'(valid0), 1);
      while (valid0 && cyc < 100) begin
         ready0 = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
         start0 = (mode == 2 && beats == 2);
         check("i0", i0, ei);
         check("j0", j0, ej);
         check("k0", k0, ek);
         check("first_k0", 32'(first_k0), 32'(ek == 0));
         check("last_k0", 32'(last_k0), 32'(ek == 1));
         check("busy0", 32'(busy0), 1);
         check("done0_run", 32'(done0), 0);
         if (ready0) begin
            beats++;
            ek++;
            if (ek == 2) begin
               ek = 0; ej++;
               if (ej == 2) begin ej = 0; ei++; end
            end
         end
         @(negedge clk);
         cyc++;
      end
      start0 = 1'b0;
      ready0 = 1'b1;
      check("run0_timeout", 32'(cyc < 100), 1);
      check("beats0", 32'(beats), 8);
      check("done0_pulse", 32'(done0), 1);
      check("busy0_fall", 32'(busy0), 0);
      check("valid0_fall", 32'(valid0), 0);
      check("i0_hold", i0, 1);
      check("j0_hold", j0, 1);
      check("k0_hold", k0, 1);
      @(negedge clk);
      check("done0_once", 32'(done0), 0);
      check("valid0_idle", 32'(valid0), 0);
      check("i0_idle", i0, 1);
      check("j0_idle", j0, 1);
      check("k0_idle", k0, 1);
   endtask

   initial begin
      int ei, ej, ek, beats, cyc;
      rst = 1'b1;
      start0 = 0; ready0 = 1; start1 = 0; ready1 = 1; start2 = 0; ready2 = 1;
      repeat (2) @(negedge clk);
      check("rst_valid", 32'(valid0), 0);
      check("rst_busy", 32'(busy0), 0);
      check("rst_done", 32'(done0), 0);
      check("rst_ijk", i0 | j0 | k0, 0);
      check("rst_flags", 32'({first_k0, last_k0}), 0);
      check("rst_addr", a0 | b0 | c0, 0);
      check("cfg_err0", 32'(cfg_err0), 0);
      check("cfg_err1", 32'(cfg_err1), 0);
      rst = 1'b0;
      @(negedge clk);

      run0(0);
      run0(1);
      run0(2);

      // Abort mid-run with reset at beat 5
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      ready0 = 1'b1;
      repeat (4) @(negedge clk);
      check("beat5_i", i0, 1);
      check("beat5_k", k0, 0);
      rst = 1'b1;
      #1;
      check("abort_valid", 32'(valid0), 0);
      check("abort_busy", 32'(busy0), 0);
      check("abort_done", 32'(done0), 0);
      check("abort_ijk", i0 | j0 | k0, 0);
      check("abort_flags", 32'({first_k0, last_k0}), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("abort_no_done", 32'(done0), 0);
         check("abort_no_valid", 32'(valid0), 0);
      end
      run0(0);

      // 2x3 * 3x2: 12 beats with address checks
      ei = 0; ej = 0; ek = 0; beats = 0; cyc = 0;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      while (valid1 && cyc < 100) begin
         check("i1", i1, ei);
         check("j1", j1, ej);
         check("k1", k1, ek);
         check("last_k1", 32'(last_k1), 32'(ek == 2));
`ifdef MMUL_SEQ_ADDR_EN
         check("a_addr1", a1, 32'(ei * 3 + ek));
         check("b_addr1", b1, 32'(ek * 2 + ej));
         check("c_addr1", c1, 32'(ei * 2 + ej));
         if (ei == 1 && ej == 0 && ek == 2) begin
            check("a_at_102", a1, 5);
            check("b_at_102", b1, 4);
            check("c_at_102", c1, 2);
         end
         if (ei == 1 && ej == 1 && ek == 2) check("c_at_112", c1, 3);
`else
         check("a_addr1_tied", a1, 0);
         check("b_addr1_tied", b1, 0);
         check("c_addr1_tied", c1, 0);
`endif
         beats++;
         ek++;
         if (ek == 3) begin
            ek = 0; ej++;
            if (ej == 2) begin ej = 0; ei++; end
         end
         @(negedge clk);
         cyc++;
      end
      check("beats1", 32'(beats), 12);
      check("done1_pulse", 32'(done1), 1);
      check("i1_hold", i1, 1);
      check("j1_hold", j1, 1);
      check("k1_hold", k1, 2);

      // Mismatched CA/RB: start must be ignored
      check("cfg_err2", 32'(cfg_err2), 1);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      repeat (3) begin
         check("cfg_valid2", 32'(valid2), 0);
         check("cfg_busy2", 32'(busy2), 0);
         check("cfg_done2", 32'(done2), 0);
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mmul_index_sequencer.md
# mmul_index_sequencer

Generates the (i, j, k) loop indices that drive one matrix multiply C = A·B: i walks rows of A, j walks columns of B, k is the inner dot-product index. It sits directly upstream of the completion arbiter, which watches the indices for the final tuple, and of the MAC datapath. The MAC datapath consumes one index tuple per valid/ready handshake, together with first/last-of-dot-product flags and, optionally, linear operand addresses.

## Interface
- RA, 2, rows of A
- CA, 2, columns of A; must equal RB
- RB, 2, rows of B
- CB, 2, columns of B

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a multiply; honoured only in IDLE
- ready  in  1  downstream accepts the current tuple
- valid  out  1  current tuple is presented
- i  out  32  row index into A and C
- j  out  32  column index into B and C
- k  out  32  inner index
- first_k  out  1  k == 0 while valid; the consumer clears its accumulator
- last_k  out  1  k == RB-1 while valid; the consumer writes C[i][j]
- a_addr  out  32  i*CA + k
- b_addr  out  32  k*CB + j
- c_addr  out  32  i*CB + j
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse after the final handshake
- cfg_err  out  1  constant 1 if CA != RB or any parameter is 0

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN when start = 1 and cfg_err = 0.
  - On that edge, i, j, k and all addresses load 0, and valid is set.
- RUN, handshake (valid && ready):
  - k advances.
  - When k == RB-1, k wraps to 0 and j advances.
  - When j == CB-1 as well, j wraps to 0 and i advances.
  - The loop order is i outer, j middle, k inner.
- RUN, handshake on the tuple (RA-1, CB-1, RB-1): go to DONE, clear valid, and hold i, j, k at the final tuple.
- DONE -> IDLE unconditionally after one cycle. done = 1 only while in DONE.
- In IDLE and DONE, i, j and k hold their last values until the next accepted start. This keeps the downstream completion condition asserted.
- start is ignored in RUN and DONE. It is ignored always when cfg_err = 1.
- Without a handshake (valid && !ready), every output holds stable.
- Address update rules, incremental with no multipliers:
  - a_addr: +1 on a k step. On a k wrap it returns to the row base. On an i step the row base increases by CA.
  - b_addr: +CB on a k step. On a k wrap it becomes j+1. On an i step it becomes 0.
  - c_addr: +1 on every j or i step.
- All arithmetic is 32-bit unsigned. Parameter products must fit in 32 bits; no overflow detection is performed.

## Timing
- Reset values: state IDLE; valid, busy and done = 0; i, j, k, a_addr, b_addr and c_addr = 0; first_k and last_k = 0.
- Reset asserted mid-RUN aborts immediately. No done pulse is produced.
- valid rises on the first edge after start is sampled, so there is 1 cycle of latency.
- With ready held at 1, throughput is one tuple per cycle. A full run is RA*CB*RB beats.
- done is high on the cycle after the final handshake. busy falls on the same edge.
- A new start is accepted at the earliest on the cycle after done, back in IDLE.
- first_k and last_k are combinational from k and valid. Both are high together when RB = 1.

## Configuration
- MMUL_SEQ_ADDR_EN defined: the address counters are built and a_addr, b_addr and c_addr behave as specified.
- Not defined: the address counters are omitted. a_addr, b_addr and c_addr are tied to 0. All other behaviour is identical.

## Test plan
- Defaults (2,2,2,2), ready = 1, start pulse -> 8 valid beats. (i,j,k) sequence is (0,0,0),(0,0,1),(0,1,0)…(1,1,1). done pulses once on the cycle after beat 8, and i, j, k hold 1,1,1 afterwards.
- Same run with ready toggling 1,0,0,1… -> every tuple is held stable while ready = 0. Exactly 8 handshakes occur, with no skipped or repeated tuple.
- Pulse start again at beat 3 of a run -> no effect. The sequence and beat count are unchanged.
- Assert rst at beat 5 -> all outputs 0 immediately and no done pulse. A fresh start then restarts from (0,0,0).
- RA=2, CA=3, RB=3, CB=2 with MMUL_SEQ_ADDR_EN -> 12 beats. At (1,0,2): a_addr = 5, b_addr = 4, c_addr = 2. At (1,1,2): c_addr = 3.
- CA=3, RB=2 -> cfg_err = 1. start is ignored: valid, busy and done stay 0.
